// File: rtl/a0_trace_fifo.sv
// a0 change tracer: queues every observed change of the cpu a0 value in a
// DEPTH-entry FIFO drained over valid/ready. Define A0_TRACE_TS_EN for cycle stamps.
module a0_trace_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int TS_WIDTH   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      a0,
  input  logic                       en,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [TS_WIDTH-1:0]        out_ts,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [DATA_WIDTH-1:0] prev;
  logic                  prev_vld;
  logic                  push_req, pop, full, do_push;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  always_comb begin
    push_req = en && (!prev_vld || (a0 != prev));
    full     = (count == CW'(DEPTH));
    pop      = out_valid && out_ready;
    do_push  = push_req && (!full || pop);
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      prev     <= '0;
      prev_vld <= 1'b0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (en) begin
        prev     <= a0;
        prev_vld <= 1'b1;
      end
      if (do_push) begin
        mem[wr_ptr] <= a0;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(pop);
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

`ifdef A0_TRACE_TS_EN
  logic [TS_WIDTH-1:0] cyc;
  logic [TS_WIDTH-1:0] ts_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc <= '0;
      for (int i = 0; i < DEPTH; i++) ts_mem[i] <= '0;
    end else begin
      cyc <= cyc + 1'b1;
      if (do_push) ts_mem[wr_ptr] <= cyc;
    end
  end

  assign out_ts = ts_mem[rd_ptr];
`else
  assign out_ts = '0;
`endif

endmodule

// File: tb/tb_a0_trace_fifo.sv
// Directed + random bench for a0_trace_fifo (DEPTH=4) against a queue scoreboard.
module tb_a0_trace_fifo;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int TSW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] a0 = '0;
  logic          en = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [TSW-1:0] out_ts;
  logic [$clog2(DEPTH):0] count;
  logic          overflow;

  a0_trace_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TS_WIDTH(TSW)) dut (
    .clk(clk), .rst(rst), .a0(a0), .en(en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ts(out_ts), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]  d;
    logic [TSW-1:0] ts;
  } ev_t;

  ev_t           q[$];
  logic [DW-1:0] m_prev;
  logic          m_pvld;
  logic          m_ovf;
  logic [TSW-1:0] m_k;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".valid"}, 64'(out_valid), 64'(q.size() != 0));
    chk({tag, ".count"}, 64'(count), 64'(q.size()));
    chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
    if (q.size() != 0) begin
      chk({tag, ".data"}, 64'(out_data), 64'(q[0].d));
      chk({tag, ".ts"}, 64'(out_ts), 64'(q[0].ts));
    end
  endtask

  // Drive one cycle, advance the scoreboard at the edge, check at the falling edge.
  task automatic tick(input logic [DW-1:0] a, input logic e, input logic r, input string tag);
    bit popv, pushv;
    ev_t ev;
    a0 = a; en = e; out_ready = r;
    @(posedge clk);
    popv  = (q.size() != 0) && r;
    pushv = e && (!m_pvld || (a != m_prev));
    if (e) begin m_prev = a; m_pvld = 1'b1; end
    if (popv) void'(q.pop_front());
    if (pushv) begin
      if (q.size() < DEPTH) begin
        ev.d = a;
`ifdef A0_TRACE_TS_EN
        ev.ts = m_k;
`else
        ev.ts = '0;
`endif
        q.push_back(ev);
      end else m_ovf = 1'b1;
    end
    m_k++;
    @(negedge clk);
    chk_state(tag);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0; a0 = 5; en = 1'b1; out_ready = 1'b0;
    repeat (n) @(posedge clk);
    q.delete(); m_prev = '0; m_pvld = 1'b0; m_ovf = 1'b0; m_k = '0;
    @(negedge clk);
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.count", 64'(count), 64'd0);
    chk("rst.ovf", 64'(overflow), 64'd0);
    chk("rst.data", 64'(out_data), 64'd0);
    chk("rst.ts", 64'(out_ts), 64'd0);
    rst = 1'b1;
  endtask

  initial begin
    // T1 reset and first sample
    do_reset(2);
    tick(5, 1, 0, "t1");
    chk("t1.data5", 64'(out_data), 64'd5);
    chk("t1.cnt1", 64'(count), 64'd1);

    // T2 no-change filter
    tick(5, 1, 1, "t2.drain");
    for (int i = 0; i < 10; i++) tick(32'hA, 1, 0, "t2");
    chk("t2.cnt1", 64'(count), 64'd1);
    chk("t2.dataA", 64'(out_data), 64'hA);

    // T3 ordering
    tick(32'hA, 1, 1, "t3.drain");
    tick(1, 1, 0, "t3"); tick(2, 1, 0, "t3"); tick(3, 1, 0, "t3");
    chk("t3.cnt3", 64'(count), 64'd3);
    chk("t3.d1", 64'(out_data), 64'd1);
    tick(3, 1, 1, "t3.pop"); chk("t3.d2", 64'(out_data), 64'd2);
    tick(3, 1, 1, "t3.pop"); chk("t3.d3", 64'(out_data), 64'd3);
    tick(3, 1, 1, "t3.pop"); chk("t3.empty", 64'(out_valid), 64'd0);

    // T4 overflow
    for (int v = 1; v <= 6; v++) tick(DW'(v), 1, 0, "t4");
    chk("t4.cnt4", 64'(count), 64'd4);
    chk("t4.ovf", 64'(overflow), 64'd1);
    for (int v = 1; v <= 4; v++) begin
      chk("t4.drain", 64'(out_data), 64'(v));
      tick(6, 1, 1, "t4.pop");
    end
    chk("t4.empty", 64'(out_valid), 64'd0);

    // T5 push+pop while full
    do_reset(1);
    for (int v = 1; v <= 4; v++) tick(DW'(v), 1, 0, "t5");
    tick(9, 1, 1, "t5.pp");
    chk("t5.cnt4", 64'(count), 64'd4);
    chk("t5.ovf0", 64'(overflow), 64'd0);
    chk("t5.d2", 64'(out_data), 64'd2);
    tick(9, 1, 1, "t5.pop"); chk("t5.d3", 64'(out_data), 64'd3);
    tick(9, 1, 1, "t5.pop"); chk("t5.d4", 64'(out_data), 64'd4);
    tick(9, 1, 1, "t5.pop"); chk("t5.d9", 64'(out_data), 64'd9);
    tick(9, 1, 1, "t5.pop"); chk("t5.empty", 64'(out_valid), 64'd0);

    // T6 enable gating and timestamp
    do_reset(1);
    for (int i = 0; i < 7; i++) tick(DW'(i + 40), 0, 0, "t6.off");
    chk("t6.cnt0", 64'(count), 64'd0);
    tick(32'h77, 1, 0, "t6");
    chk("t6.d77", 64'(out_data), 64'h77);
`ifdef A0_TRACE_TS_EN
    chk("t6.ts7", 64'(out_ts), 64'd7);
`else
    chk("t6.ts0", 64'(out_ts), 64'd0);
`endif

    // Random mix: small value range for repeats, random enable and backpressure
    for (int i = 0; i < 300; i++)
      tick(DW'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) == 0), "rnd");

    // Reset mid-operation discards queued entries
    tick(11, 1, 0, "mid"); tick(12, 1, 0, "mid");
    do_reset(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
